// File: rtl/adc_capture_dpbram.sv
// Multi-channel ADC capture ring buffer with pre-trigger history on port A,
// and a trigger-relative, wrap-free readout port (1-cycle latency) on port B.
module adc_capture_dpbram #(
  parameter int DWIDTH = 16,
  parameter int NCH    = 2,
  parameter int AWIDTH = 14,
  parameter int DEPTH  = 10000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [AWIDTH-1:0]       cfg_pre,
  input  logic [AWIDTH-1:0]       cfg_total,
  input  logic                    s_valid,
  input  logic [NCH*DWIDTH-1:0]   s_data,
  input  logic                    trig,
  output logic                    busy,
  output logic                    triggered,
  output logic                    done,
  output logic [AWIDTH-1:0]       start_addr,
  input  logic                    rd_en,
  input  logic [AWIDTH-1:0]       rd_addr,
  output logic [NCH*DWIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int                WW      = NCH * DWIDTH;
  localparam int                RA      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] DEPTH_A = AWIDTH'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_A  = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] ONE_A   = AWIDTH'(1);
  localparam logic [AWIDTH:0]   ONE_W   = (AWIDTH+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t state, state_nxt;

  logic [AWIDTH-1:0] wr_ptr, cnt, pre, pre_new, cnt_inc, trig_start;
  logic [AWIDTH:0]   tot, tot_new, tot_m1, post_cnt, post_inc, post_len;
  logic [AWIDTH:0]   rd_sum, rd_phys;
  logic [RA-1:0]     rd_idx;
  logic              capturing, wr_en, arm_ok, trig_hit, rd_oob, rd_zero;
  logic [WW-1:0]     ram [DEPTH];
  logic [WW-1:0]     ram_q;

  always_comb begin
    tot_new = ((cfg_total == '0) || ({1'b0, cfg_total} > DEPTH_W)) ? DEPTH_W : {1'b0, cfg_total};
    tot_m1  = tot_new - ONE_W;
    pre_new = ({1'b0, cfg_pre} > tot_m1) ? tot_m1[AWIDTH-1:0] : cfg_pre;
  end

  assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign wr_en     = capturing && s_valid;
  assign arm_ok    = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign trig_hit  = (state == S_WAIT) && s_valid && trig;
  assign post_len  = tot - {1'b0, pre};
  assign cnt_inc   = cnt + ONE_A;
  assign post_inc  = post_cnt + ONE_W;
  // Modular subtraction stays in range because wr_ptr and pre are both < DEPTH.
  assign trig_start = wr_ptr - pre + ((wr_ptr < pre) ? DEPTH_A : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else if (arm_ok) begin
      state_nxt = (pre_new != '0) ? S_PRE : S_WAIT;
    end else begin
      case (state)
        S_PRE:   if (s_valid && (cnt_inc == pre)) state_nxt = S_WAIT;
        S_WAIT:  if (trig_hit) state_nxt = (post_len == ONE_W) ? S_DONE : S_POST;
        S_POST:  if (s_valid && (post_inc == post_len)) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy      = capturing;
    triggered = (state == S_POST) || (state == S_DONE);
    done      = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      post_cnt   <= '0;
      tot        <= '0;
      pre        <= '0;
      start_addr <= '0;
    end else if (arm_ok) begin
      tot      <= tot_new;
      pre      <= pre_new;
      wr_ptr   <= '0;
      cnt      <= '0;
      post_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST_A) ? '0 : wr_ptr + ONE_A;
      if ((state == S_PRE) && s_valid) cnt <= cnt_inc;
      if (trig_hit) begin
        post_cnt   <= ONE_W;
        start_addr <= trig_start;
      end else if ((state == S_POST) && s_valid) begin
        post_cnt <= post_inc;
      end
    end
  end

  // Logical-to-physical readout address; out-of-window reads return zero.
  always_comb begin
    rd_sum  = {1'b0, start_addr} + {1'b0, rd_addr};
    rd_phys = (rd_sum >= DEPTH_W) ? rd_sum - DEPTH_W : rd_sum;
    rd_oob  = ({1'b0, rd_addr} >= tot) || (rd_phys >= DEPTH_W);
    rd_idx  = rd_oob ? '0 : rd_phys[RA-1:0];
  end

  // Read-first block RAM: a same-address read returns the word before the write.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr[RA-1:0]] <= s_data;
    if (rd_en) ram_q <= ram[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_zero <= rd_oob;
    end
  end

  assign rd_data = rd_zero ? '0 : ram_q;

endmodule

// File: tb/tb_adc_capture_dpbram.sv
// Bench for adc_capture_dpbram: table-driven and randomized captures against a
// sample-history model, plus hand sequences for abort, reset and collisions.
module tb_adc_capture_dpbram;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int AW = 5;
  localparam int DP = 16;
  localparam int WW = DW * NC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic          trig = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] cfg_pre = '0;
  logic [AW-1:0] cfg_total = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [WW-1:0] s_data = '0;
  logic [AW-1:0] start_addr;
  logic [WW-1:0] rd_data;
  logic          busy, triggered, done, rd_valid;

  int checks = 0;
  int failures = 0;

  // Shadow of physical RAM contents, indexed by write order within a capture.
  logic [WW-1:0] mem_model [DP];
  int            wp = 0;
  bit            cap_on = 1'b0;

  typedef struct {
    int cp;
    int ct;
    int trig_k;
    bit early;
    int exp_start;
    int exp_last;
  } vec_t;

  vec_t vecs [5];

  adc_capture_dpbram #(.DWIDTH(DW), .NCH(NC), .AWIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .cfg_pre(cfg_pre), .cfg_total(cfg_total),
    .s_valid(s_valid), .s_data(s_data), .trig(trig),
    .busy(busy), .triggered(triggered), .done(done), .start_addr(start_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_sample(input bit v, input logic [WW-1:0] d, input bit t);
    s_valid = v;
    s_data  = d;
    trig    = t;
    tick();
    if (v && cap_on) begin
      mem_model[wp] = d;
      wp = (wp + 1) % DP;
    end
    s_valid = 1'b0;
    trig    = 1'b0;
  endtask

  task automatic do_arm(input logic [AW-1:0] cp, input logic [AW-1:0] ct);
    cfg_pre   = cp;
    cfg_total = ct;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic run_capture(input int cp, input int ct, input int trig_k, input bit early,
                             input bit rnd, input int exp_start, input int exp_last);
    int m_tot, m_pre, n, trig_idx, done_n, es, el;
    bit v, t, mdone;
    logic [WW-1:0] d, exp_d;
    logic [WW-1:0] hist [$];
    m_tot = (ct == 0 || ct > DP) ? DP : ct;
    m_pre = (cp > m_tot - 1) ? m_tot - 1 : cp;
    do_arm(AW'(cp), AW'(ct));
    cap_on = 1'b1;
    wp = 0;
    chk("arm_busy", 32'(busy), 32'(1));
    chk("arm_done", 32'(done), 32'(0));
    chk("arm_triggered", 32'(triggered), 32'(0));
    n = 0; trig_idx = -1; done_n = -1; mdone = 1'b0;
    for (int cyc = 0; cyc < 400 && !mdone; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        d = rnd ? WW'($urandom) : WW'(n);
        if (trig_k >= 0) t = (n == trig_k) || (early && n == 0);
        else             t = ($urandom_range(0, 7) == 0) || (n > m_pre + 30);
      end else begin
        d = WW'($urandom);
        t = 1'($urandom_range(0, 1));
      end
      drive_sample(v, d, t);
      if (v) begin
        hist.push_back(d);
        if (trig_idx < 0 && t && n >= m_pre) trig_idx = n;
        n++;
      end
      mdone = (trig_idx >= 0) && (n >= trig_idx + m_tot - m_pre);
      chk("cap_done", 32'(done), 32'(mdone));
      chk("cap_triggered", 32'(triggered), 32'(trig_idx >= 0));
      chk("cap_busy", 32'(busy), 32'(!mdone));
      if (done && done_n < 0) done_n = n;
    end
    cap_on = 1'b0;
    if (!mdone) begin
      chk("cap_timeout_done", 32'(done), 32'(1));
    end else begin
      es = (exp_start >= 0) ? exp_start : (((trig_idx - m_pre) % DP) + DP) % DP;
      el = (exp_last >= 0) ? exp_last : trig_idx + m_tot - m_pre - 1;
      chk("start_addr", 32'(start_addr), 32'(es));
      chk("done_after_sample", 32'(done_n - 1), 32'(el));
      // Out-of-window read first, then the whole window oldest-first.
      for (int i = -1; i < m_tot; i++) begin
        rd_en   = 1'b1;
        rd_addr = (i < 0) ? AW'(m_tot) : AW'(i);
        exp_d   = (i < 0) ? '0 : hist[trig_idx - m_pre + i];
        tick();
        chk("rd_valid", 32'(rd_valid), 32'(1));
        chk("rd_data", 32'(rd_data), 32'(exp_d));
      end
      rd_en = 1'b0;
      tick();
      chk("rd_valid_drop", 32'(rd_valid), 32'(0));
      chk("rd_data_hold", 32'(rd_data), 32'(hist[trig_idx - m_pre + m_tot - 1]));
    end
  endtask

  initial begin
    logic [WW-1:0] old_w;

    vecs[0] = '{cp: 4,  ct: 10, trig_k: 20, early: 1'b0, exp_start: 0,  exp_last: 25};
    vecs[1] = '{cp: 6,  ct: 12, trig_k: 19, early: 1'b0, exp_start: 13, exp_last: 24};
    vecs[2] = '{cp: 20, ct: 8,  trig_k: 7,  early: 1'b0, exp_start: 0,  exp_last: 7};
    vecs[3] = '{cp: 0,  ct: 0,  trig_k: 5,  early: 1'b0, exp_start: 5,  exp_last: 20};
    vecs[4] = '{cp: 3,  ct: 5,  trig_k: 8,  early: 1'b1, exp_start: 5,  exp_last: 9};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_triggered", 32'(triggered), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_start_addr", 32'(start_addr), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 5; r++)
      run_capture(vecs[r].cp, vecs[r].ct, vecs[r].trig_k, vecs[r].early, 1'b0,
                  vecs[r].exp_start, vecs[r].exp_last);

    for (int r = 0; r < 12; r++)
      run_capture(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), -1, 1'b0, 1'b1, -1, -1);

    // Arm while busy must not reload the configuration.
    do_arm(AW'(2), AW'(4));
    cap_on = 1'b1; wp = 0;
    drive_sample(1'b1, 16'h0100, 1'b0);
    drive_sample(1'b1, 16'h0101, 1'b0);
    cfg_pre = AW'(0); cfg_total = AW'(1); arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armbusy_busy", 32'(busy), 32'(1));
    drive_sample(1'b1, 16'h0102, 1'b1);
    chk("armbusy_not_done", 32'(done), 32'(0));
    chk("armbusy_triggered", 32'(triggered), 32'(1));
    drive_sample(1'b1, 16'h0103, 1'b0);
    chk("armbusy_done", 32'(done), 32'(1));
    chk("armbusy_start", 32'(start_addr), 32'(0));
    cap_on = 1'b0;

    // Abort while in POST.
    do_arm(AW'(2), AW'(8));
    cap_on = 1'b1; wp = 0;
    drive_sample(1'b1, 16'h0200, 1'b0);
    drive_sample(1'b1, 16'h0201, 1'b0);
    drive_sample(1'b1, 16'h0202, 1'b1);
    drive_sample(1'b1, 16'h0203, 1'b0);
    chk("post_triggered", 32'(triggered), 32'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cap_on = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_triggered", 32'(triggered), 32'(0));

    // Arm and abort together: abort wins.
    cfg_pre = AW'(2); cfg_total = AW'(8);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("armabort_busy", 32'(busy), 32'(0));
    chk("armabort_done", 32'(done), 32'(0));

    // Read of the address being written in the same cycle returns the old word.
    do_arm(AW'(0), AW'(16));
    cap_on = 1'b1; wp = 0;
    drive_sample(1'b1, 16'hA000, 1'b1);
    drive_sample(1'b1, 16'hA001, 1'b0);
    drive_sample(1'b1, 16'hA002, 1'b0);
    old_w = mem_model[3];
    rd_en = 1'b1; rd_addr = AW'(3);
    drive_sample(1'b1, 16'hA003, 1'b0);
    rd_en = 1'b0;
    chk("coll_rd_valid", 32'(rd_valid), 32'(1));
    chk("coll_old_word", 32'(rd_data), 32'(old_w));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("coll_new_word", 32'(rd_data), 32'(16'hA003));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cap_on = 1'b0;

    // Asynchronous reset in the middle of POST.
    do_arm(AW'(1), AW'(8));
    cap_on = 1'b1; wp = 0;
    for (int k = 0; k < 4; k++) drive_sample(1'b1, WW'(16'h0300 + k), 1'b0);
    drive_sample(1'b1, 16'h0304, 1'b1);
    drive_sample(1'b1, 16'h0305, 1'b0);
    chk("rstpost_start", 32'(start_addr), 32'(3));
    rd_en = 1'b1; rd_addr = AW'(0);
    tick();
    rd_en = 1'b0;
    chk("rstpost_rd_data", 32'(rd_data), 32'(16'h0303));
    cap_on = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_triggered", 32'(triggered), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_rd_valid", 32'(rd_valid), 32'(0));
    chk("arst_start_addr", 32'(start_addr), 32'(0));
    chk("arst_rd_data", 32'(rd_data), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    drive_sample(1'b1, 16'h0400, 1'b1);
    drive_sample(1'b1, 16'h0401, 1'b1);
    chk("postrst_busy", 32'(busy), 32'(0));
    chk("postrst_triggered", 32'(triggered), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
